// File: rtl/aligner_pkg.sv
// Shared constants for the packet aligner: byte geometry of packets,
// output words and the internal packing window.
package aligner_pkg;
  localparam int TAG_BYTES     = 2;
  localparam int DATA_BYTES    = 32;
  localparam int MAX_PKT_BYTES = TAG_BYTES + DATA_BYTES;  // 34
  localparam int OUT_BYTES     = 32;
  // Worst case: 31 residual bytes plus a full 34-byte packet -> 65 bytes
  localparam int WIN_BYTES     = 2 * (OUT_BYTES + 1);     // 66
  localparam int CNT_W         = 6;                       // holds 0..34

  // Lengths above a full packet are treated as a full packet
  function automatic logic [CNT_W-1:0] clamp_len(input logic [15:0] len);
    return (len > 16'(MAX_PKT_BYTES)) ? CNT_W'(MAX_PKT_BYTES) : len[CNT_W-1:0];
  endfunction
endpackage

// File: rtl/aligner_if.sv
// Packet-in / word-out bundle of the aligner.
interface aligner_if #(
  parameter int DATA_IN_WIDTH  = 272,
  parameter int LEN_WIDTH      = 8,
  parameter int DATA_OUT_WIDTH = 256
);
  logic                      wrt_en;
  logic [DATA_IN_WIDTH-1:0]  data_in;
  logic [LEN_WIDTH-1:0]      len;
  logic [DATA_OUT_WIDTH-1:0] data_out;
  logic                      valid;
  logic                      stall;
  logic [8:0]                new_len;

  modport master (output wrt_en, data_in, len,
                  input  data_out, valid, stall, new_len);
  modport slave  (input  wrt_en, data_in, len,
                  output data_out, valid, stall, new_len);
endinterface

// File: rtl/aligner_byte_shifter.sv
// Drops the unused bytes of a packet and moves the rest up by i_shift bytes
// into the packing window; o_mask marks the window bytes the packet owns.
module aligner_byte_shifter
  import aligner_pkg::*;
#(
  parameter int DATA_IN_WIDTH = 272
) (
  input  logic [DATA_IN_WIDTH-1:0] i_pkt,
  input  logic [CNT_W-1:0]         i_len,
  input  logic [CNT_W-1:0]         i_shift,
  output logic [WIN_BYTES*8-1:0]   o_win,
  output logic [WIN_BYTES-1:0]     o_mask
);
  localparam int IN_BYTES = DATA_IN_WIDTH / 8;

  logic [WIN_BYTES-1:0]   w_lmask;
  logic [WIN_BYTES*8-1:0] w_pkt;

  assign w_lmask = (WIN_BYTES'(1) << i_len) - WIN_BYTES'(1);

  // Keep only the low i_len bytes of the packet, zero-extended to the window
  always_comb begin
    w_pkt = '0;
    for (int b = 0; b < IN_BYTES; b++)
      if (w_lmask[b]) w_pkt[b*8 +: 8] = i_pkt[b*8 +: 8];
  end

  assign o_win  = w_pkt << {i_shift, 3'b000};
  assign o_mask = w_lmask << i_shift;
endmodule

// File: rtl/aligner.sv
// Packs variable-length packets into a continuous LSB-first byte stream and
// emits it as 32-byte words. When two words become ready at once the block
// stalls its input for one cycle to drain the second.
module aligner
  import aligner_pkg::*;
#(
  parameter int DATA_IN_WIDTH  = 272,
  parameter int LEN_WIDTH      = 8,
  parameter int DATA_OUT_WIDTH = 256
) (
  input logic       clk,
  input logic       reset,
  aligner_if.slave  bus
);
  localparam int WIN_BITS = WIN_BYTES * 8;

  logic [WIN_BITS-1:0]       r_buf;   // residual bytes, zero above r_cnt
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_stall;
  logic                      r_valid;
  logic [DATA_OUT_WIDTH-1:0] r_dout;

  logic [CNT_W-1:0]          w_len;
  logic [CNT_W:0]            w_tot;
  logic [WIN_BITS-1:0]       w_win;
  logic [WIN_BITS-1:0]       w_merged;
  logic [WIN_BYTES-1:0]      w_mask;
  logic                      w_accept;

  assign w_len    = clamp_len(16'(bus.len));
  assign w_tot    = {1'b0, r_cnt} + {1'b0, w_len};
  assign w_accept = bus.wrt_en && !r_stall;

  aligner_byte_shifter #(.DATA_IN_WIDTH(DATA_IN_WIDTH)) u_shift (
    .i_pkt   (bus.data_in),
    .i_len   (w_len),
    .i_shift (r_cnt),
    .o_win   (w_win),
    .o_mask  (w_mask)
  );

  // Place the incoming bytes directly above the residual bytes
  always_comb begin
    w_merged = r_buf;
    for (int b = 0; b < WIN_BYTES; b++)
      if (w_mask[b]) w_merged[b*8 +: 8] = w_win[b*8 +: 8];
  end

  // Word emission, residual bookkeeping and one-cycle overflow stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf   <= '0;
      r_cnt   <= '0;
      r_stall <= 1'b0;
      r_valid <= 1'b0;
      r_dout  <= '0;
    end else if (r_stall) begin
      // Second word of an overflow; residual afterwards is at most 1 byte
      r_dout  <= r_buf[DATA_OUT_WIDTH-1:0];
      r_buf   <= r_buf >> DATA_OUT_WIDTH;
      r_cnt   <= r_cnt - CNT_W'(OUT_BYTES);
      r_valid <= 1'b1;
      r_stall <= 1'b0;
    end else if (w_accept) begin
      if (w_tot >= (CNT_W+1)'(OUT_BYTES)) begin
        r_dout  <= w_merged[DATA_OUT_WIDTH-1:0];
        r_buf   <= w_merged >> DATA_OUT_WIDTH;
        r_cnt   <= CNT_W'(w_tot - (CNT_W+1)'(OUT_BYTES));
        r_valid <= 1'b1;
        r_stall <= (w_tot >= (CNT_W+1)'(2*OUT_BYTES));
      end else begin
        r_buf   <= w_merged;
        r_cnt   <= CNT_W'(w_tot);
        r_valid <= 1'b0;
      end
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign bus.data_out = r_dout;
  assign bus.valid    = r_valid;
  assign bus.stall    = r_stall;
  assign bus.new_len  = 9'(r_cnt);
endmodule

// File: tb/tb_aligner.sv
// Self-checking bench for aligner: a byte-queue model predicts every cycle's
// outputs into a scoreboard; directed tests also check hand-derived values.
module tb_aligner;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aligner_if bus ();
  aligner dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic         valid;
    logic [255:0] data;
    logic [8:0]   nlen;
    logic         stall;
  } exp_t;

  exp_t         sb[$];
  logic [7:0]   mq[$];
  logic         m_stall;
  logic [255:0] m_last;
  int           n_cmp = 0;
  int           n_err = 0;
  exp_t         e;

  localparam logic [255:0] CPR =
    256'h4321_FEDC_BA98_7654_3210_FEDC_BA98_7654_3210_FEDC_BA98_7654_3210_FEDC_8765_4321;

  function automatic logic [271:0] rnd_pkt();
    logic [271:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    r[271:256] = 16'($urandom);
    return r;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_stall = 1'b0;
    m_last  = '0;
  endtask

  task automatic pop_word(inout exp_t x);
    for (int i = 0; i < 32; i++) m_last[i*8 +: 8] = mq.pop_front();
    x.valid = 1'b1;
  endtask

  // Drive one cycle, predict its outcome, clock it, then settle past the edge
  task automatic drive(input logic we, input logic [271:0] d, input logic [7:0] l);
    exp_t x;
    int   lc;
    bus.wrt_en = we; bus.data_in = d; bus.len = l;
    x.valid = 1'b0;
    if (m_stall) pop_word(x);
    else if (we) begin
      lc = (l > 8'd34) ? 34 : int'(l);
      for (int i = 0; i < lc; i++) mq.push_back(d[i*8 +: 8]);
      if (mq.size() >= 32) pop_word(x);
    end
    x.data  = m_last;
    x.nlen  = 9'(mq.size());
    m_stall = (mq.size() >= 32);
    x.stall = m_stall;
    sb.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.wrt_en = 1'b0; bus.data_in = '0; bus.len = '0;
    model_clear();
    @(posedge clk); #1;
    n_cmp++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", bus.valid); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b want 0", bus.stall); end
    n_cmp++; if (bus.new_len !== 9'd0) begin n_err++; $display("FAIL rst_new_len got %0d want 0", bus.new_len); end
    n_cmp++; if (bus.data_out !== 256'd0) begin n_err++; $display("FAIL rst_data got %h want 0", bus.data_out); end
    reset = 1'b0;
  endtask

  task automatic test_spec_vectors();
    logic [271:0] p;
    p = {CPR, 16'hFFFF};
    drive(1'b1, p, 8'h22);
    e = sb.pop_front();
    n_cmp++; if (bus.valid !== 1'b1) begin n_err++; $display("FAIL v1_valid got %b want 1", bus.valid); end
    n_cmp++; if (bus.data_out !== p[255:0]) begin n_err++; $display("FAIL v1_data got %h want %h", bus.data_out, p[255:0]); end
    n_cmp++; if (bus.new_len !== 9'd2) begin n_err++; $display("FAIL v1_new_len got %0d want 2", bus.new_len); end
    drive(1'b1, '0, 8'd0);
    e = sb.pop_front();
    n_cmp++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL v2_valid got %b want 0", bus.valid); end
    n_cmp++; if (bus.new_len !== 9'd2) begin n_err++; $display("FAIL v2_new_len got %0d want 2", bus.new_len); end
    n_cmp++; if (bus.data_out !== p[255:0]) begin n_err++; $display("FAIL v2_hold got %h want %h", bus.data_out, p[255:0]); end
    drive(1'b1, p, 8'h22);
    e = sb.pop_front();
    n_cmp++; if (bus.valid !== 1'b1) begin n_err++; $display("FAIL v3_valid got %b want 1", bus.valid); end
    n_cmp++; if (bus.data_out !== {p[239:0], 16'h4321}) begin n_err++; $display("FAIL v3_data got %h want %h", bus.data_out, {p[239:0], 16'h4321}); end
    n_cmp++; if (bus.new_len !== 9'd4) begin n_err++; $display("FAIL v3_new_len got %0d want 4", bus.new_len); end
    n_cmp++; if (bus.stall !== e.stall) begin n_err++; $display("FAIL v3_stall got %b want %b", bus.stall, e.stall); end
  endtask

  // Starts from the 4 residual bytes left by the spec vectors
  task automatic test_clamp_idle();
    logic [255:0] held;
    drive(1'b1, rnd_pkt(), 8'd40);
    e = sb.pop_front();
    n_cmp++; if (bus.new_len !== 9'd6) begin n_err++; $display("FAIL clamp_new_len got %0d want 6", bus.new_len); end
    n_cmp++; if (bus.data_out !== e.data) begin n_err++; $display("FAIL clamp_data got %h want %h", bus.data_out, e.data); end
    n_cmp++; if (bus.valid !== 1'b1) begin n_err++; $display("FAIL clamp_valid got %b want 1", bus.valid); end
    held = e.data;
    drive(1'b0, rnd_pkt(), 8'd20);
    e = sb.pop_front();
    n_cmp++; if (bus.new_len !== 9'd6) begin n_err++; $display("FAIL idle_new_len got %0d want 6", bus.new_len); end
    n_cmp++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL idle_valid got %b want 0", bus.valid); end
    n_cmp++; if (bus.data_out !== held) begin n_err++; $display("FAIL idle_hold got %h want %h", bus.data_out, held); end
  endtask

  task automatic test_back_to_back();
    logic [271:0] p;
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      drive(1'b1, rnd_pkt(), 8'd34);
      e = sb.pop_front();
      n_cmp++; if (bus.new_len !== ((k <= 16) ? 9'(2*k) : 9'd0)) begin n_err++; $display("FAIL b2b_new_len k=%0d got %0d", k, bus.new_len); end
      n_cmp++; if (bus.stall !== (k == 16)) begin n_err++; $display("FAIL b2b_stall k=%0d got %b want %b", k, bus.stall, (k == 16)); end
      n_cmp++; if (bus.valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid k=%0d got %b want 1", k, bus.valid); end
      n_cmp++; if (bus.data_out !== e.data) begin n_err++; $display("FAIL b2b_data k=%0d got %h want %h", k, bus.data_out, e.data); end
    end
    // The packet offered during the stall was dropped, so this one starts at byte 0
    p = rnd_pkt();
    drive(1'b1, p, 8'd34);
    e = sb.pop_front();
    n_cmp++; if (bus.data_out !== p[255:0]) begin n_err++; $display("FAIL post_stall_data got %h want %h", bus.data_out, p[255:0]); end
    n_cmp++; if (bus.new_len !== 9'd2) begin n_err++; $display("FAIL post_stall_new_len got %0d want 2", bus.new_len); end
  endtask

  task automatic test_reset_mid();
    logic [271:0] p;
    drive(1'b1, rnd_pkt(), 8'd34);
    void'(sb.pop_front());
    drive(1'b1, rnd_pkt(), 8'd20);
    void'(sb.pop_front());
    #3 reset = 1'b1;
    #1;
    n_cmp++; if (bus.data_out !== 256'd0) begin n_err++; $display("FAIL mid_rst_data got %h want 0", bus.data_out); end
    n_cmp++; if (bus.new_len !== 9'd0) begin n_err++; $display("FAIL mid_rst_new_len got %0d want 0", bus.new_len); end
    n_cmp++; if (bus.valid !== 1'b0 || bus.stall !== 1'b0) begin n_err++; $display("FAIL mid_rst_flags got v=%b s=%b want 0 0", bus.valid, bus.stall); end
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    p = rnd_pkt();
    drive(1'b1, p, 8'd34);
    e = sb.pop_front();
    n_cmp++; if (bus.data_out !== p[255:0]) begin n_err++; $display("FAIL mid_rst_first got %h want %h", bus.data_out, p[255:0]); end
    n_cmp++; if (bus.new_len !== e.nlen) begin n_err++; $display("FAIL mid_rst_nlen got %0d want %0d", bus.new_len, e.nlen); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), rnd_pkt(), 8'($urandom_range(0, 40)));
      e = sb.pop_front();
      n_cmp++; if (bus.valid !== e.valid) begin n_err++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, bus.valid, e.valid); end
      n_cmp++; if (bus.stall !== e.stall) begin n_err++; $display("FAIL rnd_stall cyc %0d got %b want %b", i, bus.stall, e.stall); end
      n_cmp++; if (bus.new_len !== e.nlen) begin n_err++; $display("FAIL rnd_new_len cyc %0d got %0d want %0d", i, bus.new_len, e.nlen); end
      n_cmp++; if (bus.data_out !== e.data) begin n_err++; $display("FAIL rnd_data cyc %0d got %h want %h", i, bus.data_out, e.data); end
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_clamp_idle();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/aligner.md
ALIGNER -- requirements
Module: aligner

Interface
REQ-001 Parameters: DATA_IN_WIDTH, default 272, input packet width (256-bit compressed data above a 16-bit tag); LEN_WIDTH, default 8, length field width; DATA_OUT_WIDTH, default 256, packed output word width.
REQ-002 One clock; reset is asynchronous and active-high; ports named clk and reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 wrt_en  input  1  write enable; input packet offered this cycle.
REQ-006 data_in  input  272  packet {cpr_data[255:0], tag[15:0]}; valid bytes are the low len bytes.
REQ-007 len  input  8  packet length in bytes, tag included (0..34).
REQ-008 data_out  output  256  packed output word, byte 0 at bits [7:0].
REQ-009 valid  output  1  data_out holds a new 32-byte word this cycle.
REQ-010 stall  output  1  input ignored this cycle; upstream holds its packet.
REQ-011 new_len  output  9  registered residual byte count held in the packing buffer (0..33).

Function
REQ-012 The block concatenates the valid bytes of successive packets, LSB-first, into a continuous byte stream and emits it as 32-byte words.
REQ-013 Internal buffer holds the residual byte count R (0..33); new packet bytes are placed directly above the R residual bytes.
REQ-014 Input is accepted on a rising edge when wrt_en=1 and stall=0; otherwise data_in and len are ignored.
REQ-015 len > 34 is clamped to 34; len=0 accepted as a no-op (R unchanged, valid=0).
REQ-016 On acceptance, T=R+len; if T>=32, data_out <= low 32 bytes of buffer, valid <= 1, R <= T-32; else valid <= 0, R <= T.
REQ-017 Latency: data_out/valid registered, one cycle after the accepting edge.
REQ-018 If R>=32 after an edge (T>=64), stall=1 in the following cycle; on that edge the block emits the low 32 bytes (valid=1), shifts down, R <= R-32, and accepts no input.
REQ-019 stall is a registered output; it stays asserted for exactly one cycle per overflow.
REQ-020 valid=0 on any edge that emits no word; data_out holds its last value while valid=0.
REQ-021 new_len equals R after each edge.
REQ-022 Bytes beyond position R+len in the buffer are zero; unused data_in bytes never enter the stream.

Reset
REQ-023 reset asserted: data_out=0, valid=0, stall=0, new_len=0, buffer cleared, immediately and independent of clk.
REQ-024 reset mid-operation discards residual bytes; the first packet after release starts at byte 0.

Structure
REQ-025 Shared package holds constants: TAG_BYTES=2, DATA_BYTES=32, MAX_PKT_BYTES=34, OUT_BYTES=32.
REQ-026 One sub-module, aligner_byte_shifter: combinational byte-granular left shift of the 272-bit packet by R bytes into a 66-byte window with a byte mask.
REQ-027 The existing FIFO module (DATA_WIDTH, ADDR_WIDTH, push/pop/empty/full/almost_full/count) buffers packets upstream and words downstream; it is not modified by this block.

Verification
REQ-028 Reset: assert reset mid-clock -> all outputs 0 immediately, new_len=0.
REQ-029 From R=0, packet tag=16'hFFFF, cpr_data=256'h4321_FEDC_..._8765_4321, len=8'h22 -> next cycle valid=1, data_out=data_in[255:0], new_len=2 (residual 16'h4321).
REQ-030 Then len=0, data_in=0 -> valid=0, new_len=2, data_out unchanged.
REQ-031 Then same 34-byte packet -> valid=1, data_out={data_in[239:0],16'h4321}, new_len=4.
REQ-032 Sixteen back-to-back 34-byte packets from R=0 -> R grows 2 per word to 30; 16th gives T=64 -> valid=1, stall=1 next cycle, second word emitted, new_len=0, input during stall ignored.
REQ-033 Packet with len=40 -> treated as len=34; packet with wrt_en=0 -> no state change.
